// File: rtl/axis_pack_result.sv
// axis_pack_result: serializes wide per-row result words from the PE engine
// onto a narrow AXI-Stream master toward the DMA.
//
// The block holds up to two rows in a ping-pong buffer. Each row is sent as
// BEATS beats, least significant first. tlast is raised on the final beat of
// every ROWS_PER_FRAME-th row, and frame_done pulses one cycle after the tlast
// beat handshakes.
//
// Optional build macro PACK_SAT16_EN: when defined, each signed accumulator is
// saturated to a signed 16-bit lane before buffering. This halves PACKED_W at
// the defaults. When it is undefined, the raw ACC_WIDTH lanes pass through.
module axis_pack_result #(
  parameter int KERNEL_SIZE    = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int M_WIDTH        = 128,
  parameter int ROWS_PER_FRAME = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [ACC_WIDTH*KERNEL_SIZE-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [M_WIDTH-1:0]               m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             frame_done
);

`ifdef PACK_SAT16_EN
  localparam int LANE_W = 16;
`else
  localparam int LANE_W = ACC_WIDTH;
`endif
  localparam int PACKED_W = LANE_W * KERNEL_SIZE;
  localparam int BEATS    = PACKED_W / M_WIDTH;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W    = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS_PER_FRAME - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Lane packing: optionally saturate each accumulator to 16 bits.
  // ---------------------------------------------------------------------
  logic [PACKED_W-1:0] packed_row;

  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_lane
`ifdef PACK_SAT16_EN
      logic [ACC_WIDTH-1:0] acc;
      logic                 pos_ovf;
      logic                 neg_ovf;
      assign acc = s_axis_tdata[gi*ACC_WIDTH +: ACC_WIDTH];
      // The value fits in 16 signed bits only if bits [ACC_WIDTH-1:15]
      // all equal the sign bit. Otherwise the sign picks the rail.
      assign pos_ovf = ~acc[ACC_WIDTH-1] &  (|acc[ACC_WIDTH-2:15]);
      assign neg_ovf =  acc[ACC_WIDTH-1] & ~(&acc[ACC_WIDTH-2:15]);
      assign packed_row[gi*16 +: 16] = pos_ovf ? 16'h7FFF :
                                       neg_ovf ? 16'h8000 : acc[15:0];
`else
      assign packed_row[gi*LANE_W +: LANE_W] = s_axis_tdata[gi*ACC_WIDTH +: ACC_WIDTH];
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PACKED_W-1:0] buf_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                s_ready_q, s_ready_d;
  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
  logic                frame_done_q, frame_done_d;

  logic push;
  logic beat_hs;
  logic beat_last;
  logic row_last;
  logic pop;

  // The head row is split into beat slots, so the output is a plain mux of
  // buffer registers selected by beat_cnt.
  logic [PACKED_W-1:0] head_row;
  logic [M_WIDTH-1:0]  head_beats [BEATS];

  assign head_row = buf_q[rd_ptr_q];

  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign head_beats[gi] = head_row[gi*M_WIDTH +: M_WIDTH];
    end
  endgenerate

  // Handshake decode and next-state computation for the buffer, the
  // serializer and the framing counters.
  always_comb begin
    push         = s_axis_tvalid && s_ready_q;
    beat_hs      = (state_q == SEND) && m_axis_tready;
    beat_last    = (beat_cnt_q == LAST_BEAT);
    row_last     = (row_cnt_q == LAST_ROW);
    pop          = beat_hs && beat_last;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_cnt_d   = beat_cnt_q;
    row_cnt_d    = row_cnt_q;
    state_d      = state_q;
    frame_done_d = 1'b0;

    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (beat_hs) begin
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + BEAT_W'(1);
    end

    if (pop) begin
      row_cnt_d    = row_last ? '0 : row_cnt_q + ROW_W'(1);
      frame_done_d = row_last;
    end

    case (state_q)
      // Move to SEND the cycle a row lands, so beat 0 appears one cycle
      // after the input handshake.
      IDLE: begin
        if (push || (count_q != 2'd0)) begin
          state_d    = SEND;
          beat_cnt_d = '0;
        end
      end
      // Keep sending while a row is still buffered after a pop,
      // including a row written in the same cycle.
      SEND: begin
        if (pop && (count_d == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tready is registered from the next occupancy, so it never depends
    // combinationally on m_axis_tready.
    s_ready_d = (count_d != 2'd2);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      s_ready_q    <= 1'b0;
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      row_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      s_ready_q    <= s_ready_d;
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      row_cnt_q    <= row_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row storage. The write slot never equals the head slot while it is
  // being sent, so the beats on the output stay stable.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= packed_row;
    end
  end

  // Output drive: the outputs come only from registers, and they are zero
  // when nothing is being sent.
  always_comb begin
    s_axis_tready = s_ready_q;
    m_axis_tvalid = (state_q == SEND);
    m_axis_tdata  = (state_q == SEND) ? head_beats[beat_cnt_q] : '0;
    m_axis_tlast  = (state_q == SEND) && row_last && beat_last;
    frame_done    = frame_done_q;
  end

endmodule

// File: tb/tb_axis_pack_result.sv
// Directed testbench for axis_pack_result. It runs a linear sequence of
// steps, and a scoreboard queue holds the expected beats.
`timescale 1ns/1ps
module tb_axis_pack_result;

  localparam int KS   = 16;
  localparam int AW   = 32;
  localparam int MW   = 128;
  localparam int RPF  = 16;
  localparam int IN_W = KS * AW;
`ifdef PACK_SAT16_EN
  localparam int LW = 16;
`else
  localparam int LW = AW;
`endif
  localparam int PW    = LW * KS;
  localparam int BEATS = PW / MW;

  logic            clk;
  logic            rstn;
  logic [IN_W-1:0] s_tdata;
  logic            s_valid;
  logic            s_ready;
  logic [MW-1:0]   m_tdata;
  logic            m_valid;
  logic            m_ready;
  logic            m_tlast;
  logic            frame_done;

  axis_pack_result #(
    .KERNEL_SIZE   (KS),
    .ACC_WIDTH     (AW),
    .M_WIDTH       (MW),
    .ROWS_PER_FRAME(RPF)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tlast (m_tlast),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] data;
    logic          last;
    logic          eor;
  } beat_t;

  beat_t         exp_q[$];
  int            vec = 0;
  int            errs = 0;
  int            occ = 0;
  int            frame_row = 0;
  int            nbeats = 0;
  int            fd_cnt = 0;
  int            tlast_cnt = 0;
  int            tlast_at = 0;
  int            row_id = 0;
  int            rows_left = 0;
  bit            stall_prev = 0;
  logic [MW-1:0] stall_data;
  logic          stall_last;

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mk_row(input int id);
    logic [IN_W-1:0] r;
    for (int k = 0; k < KS; k++) begin
      r[k*AW +: AW] = AW'(id * 256 + k + 1);
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] pack(input logic [IN_W-1:0] r);
    logic [PW-1:0] p;
`ifdef PACK_SAT16_EN
    logic signed [AW-1:0] v;
    logic [15:0] lane;
    for (int k = 0; k < KS; k++) begin
      v = $signed(r[k*AW +: AW]);
      if (v > 32767) lane = 16'h7FFF;
      else if (v < -32768) lane = 16'h8000;
      else lane = v[15:0];
      p[k*16 +: 16] = lane;
    end
`else
    p = r;
`endif
    return p;
  endfunction

  // One clock cycle. The task scores the handshakes that occur at the coming
  // edge, then checks the registered outputs at the next falling edge.
  task automatic tick();
    bit            rst_now;
    bit            push;
    bit            fd_next;
    beat_t         e;
    logic [PW-1:0] pk;
    rst_now = !rstn;
    push    = 0;
    fd_next = 0;
    if (!rst_now) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          vec++;
          errs++;
          $error("FAIL unexpected_beat: observed %0h expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_tdata, e.data);
          chk("beat_last", MW'(m_tlast), MW'(e.last));
          nbeats++;
          if (m_tlast) begin
            tlast_cnt++;
            tlast_at = nbeats;
          end
          if (e.last) fd_next = 1;
          if (e.eor) occ--;
        end
      end
      push       = s_valid && s_ready;
      stall_prev = m_valid && !m_ready;
      stall_data = m_tdata;
      stall_last = m_tlast;
    end
    @(posedge clk);
    @(negedge clk);
    if (rst_now) begin
      exp_q.delete();
      occ        = 0;
      frame_row  = 0;
      stall_prev = 0;
      chk("rst_s_ready", MW'(s_ready), '0);
      chk("rst_m_valid", MW'(m_valid), '0);
      chk("rst_m_tlast", MW'(m_tlast), '0);
      chk("rst_frame_done", MW'(frame_done), '0);
      chk("rst_m_tdata", m_tdata, '0);
    end else begin
      if (push) begin
        pk = pack(s_tdata);
        for (int b = 0; b < BEATS; b++) begin
          e.data = pk[b*MW +: MW];
          e.eor  = (b == BEATS - 1);
          e.last = (b == BEATS - 1) && (frame_row == RPF - 1);
          exp_q.push_back(e);
        end
        frame_row = (frame_row == RPF - 1) ? 0 : frame_row + 1;
        occ++;
        row_id++;
        rows_left--;
        s_tdata = mk_row(row_id);
        s_valid = (rows_left > 0);
      end
      chk("frame_done", MW'(frame_done), MW'(fd_next));
      if (frame_done) fd_cnt++;
      chk("s_ready", MW'(s_ready), MW'(occ < 2));
      if (stall_prev) begin
        chk("hold_valid", MW'(m_valid), MW'(1'b1));
        chk("hold_data", m_tdata, stall_data);
        chk("hold_last", MW'(m_tlast), MW'(stall_last));
      end
    end
  endtask

  task automatic offer(input int n);
    rows_left = n;
    s_tdata   = mk_row(row_id);
    s_valid   = 1'b1;
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || rows_left != 0) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (exp_q.size() != 0 || rows_left != 0) begin
      vec++;
      errs++;
      $error("FAIL drain_timeout: observed %0d beats pending expected 0", exp_q.size());
    end
  endtask

  task automatic run_until_beats(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (nbeats < target && cyc < budget) begin
      tick();
      cyc++;
    end
    chk_i("beat_target", nbeats, target);
  endtask

  initial begin
    int            nb0;
    logic [MW-1:0] exp_beat;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_tdata = '0;
    m_ready = 1'b1;

    // Reset, then release.
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Step 1: a single row, lane k = k+1. Beat 0 appears one cycle after accept.
`ifdef PACK_SAT16_EN
    exp_beat = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
`else
    exp_beat = 128'h00000004_00000003_00000002_00000001;
`endif
    row_id = 0;
    offer(1);
    tick();
    chk("t1_beat0_valid", MW'(m_valid), MW'(1'b1));
    chk("t1_beat0_data", m_tdata, exp_beat);
    chk("t1_beat0_last", MW'(m_tlast), '0);
    for (int b = 1; b < BEATS; b++) begin
      tick();
      chk("t1_no_bubble", MW'(m_valid), MW'(1'b1));
    end
    tick();
    chk("t1_idle_after", MW'(m_valid), '0);

    // Step 2: two full frames back-to-back after a reset pulse.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    fd_cnt    = 0;
    tlast_cnt = 0;
    nb0       = nbeats;
    offer(RPF);
    drain(400);
    chk_i("f1_tlast_count", tlast_cnt, 1);
    chk_i("f1_tlast_pos", tlast_at - nb0, RPF * BEATS);
    chk_i("f1_frame_done_count", fd_cnt, 1);
    offer(RPF);
    drain(400);
    chk_i("f2_tlast_count", tlast_cnt, 2);
    chk_i("f2_tlast_pos", tlast_at - nb0, 2 * RPF * BEATS);
    chk_i("f2_frame_done_count", fd_cnt, 2);

    // Step 3: stall the output mid-row for 10 cycles while 3 rows are offered.
    nb0 = nbeats;
    offer(3);
    run_until_beats(nb0 + 2, 20);
    m_ready = 1'b0;
    repeat (10) tick();
    chk("bp_s_ready_low", MW'(s_ready), '0);
    chk_i("bp_rows_waiting", rows_left, 1);
    m_ready = 1'b1;
    drain(100);
    chk_i("bp_total_beats", nbeats - nb0, 3 * BEATS);

    // Step 4: toggle the output ready every cycle while rows are offered continuously.
    nb0 = nbeats;
    offer(8);
    for (int c = 0; c < 300 && (exp_q.size() != 0 || rows_left != 0); c++) begin
      m_ready = ~m_ready;
      tick();
    end
    m_ready = 1'b1;
    drain(50);
    chk_i("tog_total_beats", nbeats - nb0, 8 * BEATS);

    // Step 5: reset after 2 beats of row 5. The next frame starts at row 0.
    nb0 = nbeats;
    offer(20);
    run_until_beats(nb0 + 5 * BEATS + 2, 200);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    tlast_cnt = 0;
    fd_cnt    = 0;
    nb0       = nbeats;
    offer(RPF);
    drain(400);
    chk_i("rst_frame_tlast_count", tlast_cnt, 1);
    chk_i("rst_frame_tlast_pos", tlast_at - nb0, RPF * BEATS);
    chk_i("rst_frame_done_count", fd_cnt, 1);

`ifdef PACK_SAT16_EN
    // Step 6: saturation of the lanes to signed 16 bits.
    rows_left = 1;
    s_tdata   = '0;
    s_tdata[0*AW +: AW] = 32'h00010000;
    s_tdata[1*AW +: AW] = 32'hFFFF0000;
    s_tdata[2*AW +: AW] = 32'h00001234;
    s_tdata[3*AW +: AW] = 32'hFFFFFFFE;
    s_valid   = 1'b1;
    tick();
    exp_beat = {64'h0, 16'hFFFE, 16'h1234, 16'h8000, 16'h7FFF};
    chk("sat_beat0", m_tdata, exp_beat);
    tick();
    chk("sat_beat1", m_tdata, '0);
    tick();
    chk("sat_two_beats", MW'(m_valid), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
